// File: rtl/mips32_arb_pkg.sv
// Shared types and default widths for the MIPS32 instruction/data memory arbiter.
package mips32_arb_pkg;

  localparam int ARB_ADDR_W = 10;
  localparam int ARB_DATA_W = 32;

  typedef enum logic {
    IDLE,
    WAIT_RD
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    DATA
  } arb_owner_e;

endpackage

// File: rtl/mips32_arb_prio.sv
// Fetch/data winner select with fetch anti-starvation counter; purely combinational grants.
// Data wins contention until fetch has lost STARVE_MAX consecutive IDLE arbitrations.
module mips32_arb_prio
  import mips32_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic if_req,
  input  logic if_flush,
  input  logic d_req,
  input  logic mem_gnt,
  output logic fetch_win,
  output logic data_win,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    fetch_win    = idle && if_req && !if_flush && (!d_req || (starve_cnt_q >= SMAX));
    data_win     = idle && d_req && !fetch_win;
    if_gnt       = fetch_win && mem_gnt;
    d_gnt        = data_win && mem_gnt;
    starve_cnt_d = starve_cnt_q;
    // Counter only moves on IDLE arbitration cycles; it holds across WAIT_RD.
    if (idle) begin
      if (!if_req || if_gnt) begin
        starve_cnt_d = '0;
      end else if (d_gnt && (starve_cnt_q < SMAX)) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shared I/D memory arbiter: one outstanding read, registered rvalid/rdata (memory latency + 1),
// stores complete on d_gnt. Optional counters under MIPS32_MEM_ARB_STATS_EN.
module mips32_mem_arbiter
  import mips32_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MIPS32_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_if_stall
`endif
);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic              discard_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              idle, fetch_win, data_win;

  assign idle = (state_q == IDLE);

  mips32_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle     (idle),
    .if_req   (if_req),
    .if_flush (if_flush),
    .d_req    (d_req),
    .mem_gnt  (mem_gnt),
    .fetch_win(fetch_win),
    .data_win (data_win),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt)
  );

  always_comb begin
    mem_req   = fetch_win || data_win;
    mem_we    = data_win && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_win) begin
      mem_addr = if_addr;
    end else if (data_win) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= NONE;
      discard_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Responses arriving here are stale and dropped.
          if (if_gnt) begin
            state_q <= WAIT_RD;
            owner_q <= FETCH;
          end else if (d_gnt && !d_we) begin
            state_q <= WAIT_RD;
            owner_q <= DATA;
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            state_q   <= IDLE;
            owner_q   <= NONE;
            discard_q <= 1'b0;
            // A flush coinciding with the response still kills it.
            if ((owner_q == FETCH) && !discard_q && !if_flush) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end
            if (owner_q == DATA) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_rdata;
            end
          end else if (if_flush && (owner_q == FETCH)) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

`ifdef MIPS32_MEM_ARB_STATS_EN
  logic [31:0] stat_if_grants_q, stat_d_grants_q, stat_if_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_grants_q <= '0;
      stat_d_grants_q  <= '0;
      stat_if_stall_q  <= '0;
    end else begin
      if (if_gnt)           stat_if_grants_q <= stat_if_grants_q + 32'd1;
      if (d_gnt)            stat_d_grants_q  <= stat_d_grants_q + 32'd1;
      if (if_req && !if_gnt) stat_if_stall_q <= stat_if_stall_q + 32'd1;
    end
  end

  assign stat_if_grants = stat_if_grants_q;
  assign stat_d_grants  = stat_d_grants_q;
  assign stat_if_stall  = stat_if_stall_q;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model and a behavioural memory with variable latency.
module tb_mips32_mem_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
`ifdef MIPS32_MEM_ARB_STATS_EN
  logic [31:0]   stat_if_grants, stat_d_grants, stat_if_stall;
`endif

  always #5 clk = ~clk;

  mips32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MIPS32_MEM_ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants), .stat_if_stall(stat_if_stall)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Behavioural memory
  logic [DW-1:0] shadow [0:1023];
  int            lat = 1, gnt_pct = 100, stray_pct = 0;
  bit            pend = 0;
  int            cnt = 0;
  logic [DW-1:0] pdata = '0;

  // Next-cycle requester inputs
  bit            nx_if_req = 0, nx_if_flush = 0, nx_d_req = 0, nx_d_we = 0;
  logic [AW-1:0] nx_if_addr = '0, nx_d_addr = '0;
  logic [DW-1:0] nx_d_wdata = '0;

  // Transaction-level model: busy flag, owner (0 none, 1 fetch, 2 data), lost-arbitration count
  bit            m_busy = 0, m_disc = 0;
  int            m_owner = 0, m_starve = 0;
  bit            e_if_rv = 0, e_d_rv = 0, e_if_gnt = 0, e_d_gnt = 0;
  logic [DW-1:0] e_if_rd = '0, e_d_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_disc = 0; m_owner = 0; m_starve = 0;
    e_if_rv = 0; e_d_rv = 0; e_if_rd = '0; e_d_rd = '0;
  endtask

  task automatic step();
    bit fw, dw;
    @(posedge clk);
    #1;
    if_req = nx_if_req; if_addr = nx_if_addr; if_flush = nx_if_flush;
    d_req = nx_d_req; d_we = nx_d_we; d_addr = nx_d_addr; d_wdata = nx_d_wdata;
    mem_gnt = ($urandom_range(99) < gnt_pct);
    mem_rvalid = 1'b0;
    mem_rdata = $urandom();
    if (pend) begin
      if (cnt <= 1) begin
        mem_rvalid = 1'b1; mem_rdata = pdata; pend = 0;
      end else begin
        cnt--;
      end
    end else if ($urandom_range(99) < stray_pct) begin
      mem_rvalid = 1'b1;
    end
    #4;
    fw = !m_busy && if_req && !if_flush && (!d_req || m_starve >= SMAX);
    dw = !m_busy && !fw && d_req;
    e_if_gnt = fw && mem_gnt;
    e_d_gnt  = dw && mem_gnt;
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("mem_req", mem_req, fw || dw);
    if (fw || dw) begin
      chk("mem_we", mem_we, dw && d_we);
      chk("mem_addr", mem_addr, fw ? if_addr : d_addr);
      if (fw || d_we) chk("mem_wdata", mem_wdata, fw ? '0 : d_wdata);
    end
    chk("if_rvalid", if_rvalid, e_if_rv);
    chk("d_rvalid", d_rvalid, e_d_rv);
    chk("if_rdata", if_rdata, e_if_rd);
    chk("d_rdata", d_rdata, e_d_rd);
    // memory side effect of an accepted request
    if (e_if_gnt || e_d_gnt) begin
      if (e_d_gnt && d_we) begin
        shadow[d_addr] = d_wdata;
      end else begin
        pend = 1; cnt = lat;
        pdata = e_if_gnt ? shadow[if_addr] : shadow[d_addr];
      end
    end
    // model state for the next cycle
    e_if_rv = 0; e_d_rv = 0;
    if (!m_busy) begin
      if (e_if_gnt) begin
        m_busy = 1; m_owner = 1; m_starve = 0;
      end else begin
        if (!if_req) m_starve = 0;
        else if (e_d_gnt && m_starve < SMAX) m_starve++;
        if (e_d_gnt && !d_we) begin m_busy = 1; m_owner = 2; end
      end
    end else if (mem_rvalid) begin
      if (m_owner == 1 && !m_disc && !if_flush) begin e_if_rv = 1; e_if_rd = mem_rdata; end
      if (m_owner == 2) begin e_d_rv = 1; e_d_rd = mem_rdata; end
      m_busy = 0; m_owner = 0; m_disc = 0;
    end else if (if_flush && m_owner == 1) begin
      m_disc = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    nx_if_req = 0; nx_if_flush = 0; nx_d_req = 0;
    if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0;
    model_reset();
    #4;
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = $urandom();
    do_reset();

    // Fetch-only read
    shadow[5] = 32'hDEADBEEF;
    nx_if_req = 1; nx_if_addr = 10'd5;
    step(); chk("t1_if_gnt", if_gnt, 1); chk("t1_mem_addr", mem_addr, 5);
    nx_if_req = 0;
    step(); chk("t1_rv_early", if_rvalid, 0);
    step(); chk("t1_if_rvalid", if_rvalid, 1); chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_d_rvalid", d_rvalid, 0);

    // Contention: data first, fetch at the next IDLE cycle
    shadow[7] = 32'h0000_7777; shadow[11] = 32'hB0B0_1111;
    nx_if_req = 1; nx_if_addr = 10'd11; nx_d_req = 1; nx_d_we = 0; nx_d_addr = 10'd7;
    step(); chk("t2_d_gnt", d_gnt, 1); chk("t2_if_gnt", if_gnt, 0);
    nx_d_req = 0;
    step(); chk("t2_wait_if_gnt", if_gnt, 0);
    step(); chk("t2_d_rvalid", d_rvalid, 1); chk("t2_d_rdata", d_rdata, 32'h0000_7777);
    chk("t2_if_gnt_after", if_gnt, 1);
    nx_if_req = 0;
    step(); step(); chk("t2_if_rvalid", if_rvalid, 1); chk("t2_if_rdata", if_rdata, 32'hB0B0_1111);

    // Starvation: four stores win, fetch takes the fifth IDLE cycle
    nx_if_req = 1; nx_if_addr = 10'd20; nx_d_req = 1; nx_d_we = 1;
    for (int k = 0; k < 4; k++) begin
      nx_d_addr = AW'(30 + k); nx_d_wdata = DW'(32'hA0 + k);
      step(); chk("t3_d_gnt", d_gnt, 1); chk("t3_if_gnt", if_gnt, 0);
    end
    nx_d_addr = 10'd40;
    step(); chk("t3_fetch_wins", if_gnt, 1); chk("t3_d_lost", d_gnt, 0);
    nx_d_req = 0; nx_if_req = 0;
    step(); step(); chk("t3_if_rvalid", if_rvalid, 1);
    nx_if_req = 1; nx_if_addr = 10'd21; nx_d_req = 1; nx_d_we = 1; nx_d_addr = 10'd41;
    step(); chk("t3_cnt_cleared", d_gnt, 1);
    nx_d_req = 0;
    step(); chk("t3_if_gnt2", if_gnt, 1);
    nx_if_req = 0;
    step(); step();

    // Flush
    nx_if_req = 1; nx_if_addr = 10'd2; nx_if_flush = 1;
    step(); chk("t4_flush_blocks", if_gnt, 0); chk("t4_flush_noreq", mem_req, 0);
    nx_if_flush = 0; lat = 2;
    step(); chk("t4_if_gnt", if_gnt, 1);
    nx_if_req = 0; nx_if_flush = 1;
    step();
    nx_if_flush = 0;
    step();
    step(); chk("t4_killed", if_rvalid, 0);
    step(); chk("t4_killed2", if_rvalid, 0);
    lat = 1; nx_if_req = 1; nx_if_addr = 10'd2;
    step();
    nx_if_req = 0; nx_if_flush = 1;
    step();
    nx_if_flush = 0;
    step(); chk("t4_same_cycle_kill", if_rvalid, 0);
    shadow[9] = 32'h0999_0999;
    nx_if_req = 1; nx_if_addr = 10'd9;
    step(); chk("t4_gnt9", if_gnt, 1);
    nx_if_req = 0;
    step(); step(); chk("t4_rv9", if_rvalid, 1); chk("t4_rd9", if_rdata, 32'h0999_0999);

    // Store
    nx_d_req = 1; nx_d_we = 1; nx_d_addr = 10'd3; nx_d_wdata = 32'h12;
    step(); chk("t5_d_gnt", d_gnt, 1); chk("t5_mem_we", mem_we, 1);
    chk("t5_mem_addr", mem_addr, 3); chk("t5_mem_wdata", mem_wdata, 32'h12);
    nx_d_req = 0; nx_if_req = 1; nx_if_addr = 10'd3;
    step(); chk("t5_still_idle", if_gnt, 1);
    nx_if_req = 0;
    step(); step(); chk("t5_readback", if_rdata, 32'h12); chk("t5_no_d_rvalid", d_rvalid, 0);

    // Reset while a fetch read is outstanding; its response arrives after release
    nx_if_req = 1; nx_if_addr = 10'd5;
    step(); chk("t6_gnt", if_gnt, 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(); chk("t6_no_rvalid", if_rvalid, 0); chk("t6_rdata", if_rdata, 0);
    end

    // Randomized traffic
    gnt_pct = 75; stray_pct = 5;
    for (int c = 0; c < 4000; c++) begin
      lat = $urandom_range(3, 1);
      nx_if_flush = ($urandom_range(99) < 10);
      step();
      if (e_if_gnt || !nx_if_req) begin
        nx_if_req = ($urandom_range(99) < 60);
        nx_if_addr = AW'($urandom_range(63));
      end
      if (e_d_gnt || !nx_d_req) begin
        nx_d_req = ($urandom_range(99) < 50);
        nx_d_we = ($urandom_range(99) < 40);
        nx_d_addr = AW'($urandom_range(63));
        nx_d_wdata = $urandom();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
